// File: rtl/lsu.sv
// lsu: load/store unit between EXU and WBU.
// Accepts one instruction at a time and issues at most one memory access.
// Load data is aligned and extended before it is handed to WBU.
// The CSR/ebreak/ecall/mret sideband passes through unchanged.
module lsu (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_inst,
  input  logic [31:0] in_result,
  input  logic [31:0] in_wdata,
  input  logic [4:0]  in_rd,
  input  logic        in_reg_wen,
  input  logic        in_mem_ren,
  input  logic        in_mem_wen,
  input  logic [48:0] in_side,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  output logic        mem_req_wen,
  output logic [31:0] mem_req_wdata,
  output logic [3:0]  mem_req_wmask,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst,
  output logic [31:0] out_result,
  output logic [4:0]  out_rd,
  output logic        out_reg_wen,
  output logic [48:0] out_side
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, OUT} state_t;

  state_t      state;
  logic [1:0]  in_off;
  logic [2:0]  in_f3;
  logic [3:0]  st_wmask;
  logic [31:0] st_wdata;
  logic [1:0]  ld_off;
  logic [2:0]  ld_f3;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] load_data;

  assign in_ready = (state == IDLE);
  assign in_off   = in_result[1:0];
  assign in_f3    = in_inst[14:12];

  // The latched address and instruction select the lane of the response word.
  assign ld_off   = out_result[1:0];
  assign ld_f3    = out_inst[14:12];
  assign ld_byte  = 8'(mem_rsp_rdata >> {ld_off, 3'b000});
  assign ld_half  = 16'(mem_rsp_rdata >> {ld_off[1], 4'b0000});

  // Byte strobes and lane-replicated store data for the incoming instruction.
  always_comb begin
    st_wmask = 4'b1111;
    st_wdata = in_wdata;
    case (in_f3)
      3'd0: begin
        st_wmask = 4'b0001 << in_off;
        st_wdata = {4{in_wdata[7:0]}};
      end
      3'd1: begin
        st_wmask = 4'b0011 << {in_off[1], 1'b0};
        st_wdata = {2{in_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // Sign/zero extension of the selected byte or half; unknown widths act as LW.
  always_comb begin
    load_data = mem_rsp_rdata;
    case (ld_f3)
      3'd0:    load_data = {{24{ld_byte[7]}}, ld_byte};
      3'd4:    load_data = {24'b0, ld_byte};
      3'd1:    load_data = {{16{ld_half[15]}}, ld_half};
      3'd5:    load_data = {16'b0, ld_half};
      default: load_data = mem_rsp_rdata;
    endcase
  end

  // Control FSM; every payload and bus field is a register latched at accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      mem_req_valid <= 1'b0;
      mem_req_addr  <= 32'b0;
      mem_req_wen   <= 1'b0;
      mem_req_wdata <= 32'b0;
      mem_req_wmask <= 4'b0;
      out_valid     <= 1'b0;
      out_pc        <= 32'b0;
      out_inst      <= 32'b0;
      out_result    <= 32'b0;
      out_rd        <= 5'b0;
      out_reg_wen   <= 1'b0;
      out_side      <= 49'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            out_pc      <= in_pc;
            out_inst    <= in_inst;
            out_result  <= in_result;
            out_rd      <= in_rd;
            out_reg_wen <= in_reg_wen & (in_rd != 5'd0);
            out_side    <= in_side;
            if (in_mem_ren | in_mem_wen) begin
              mem_req_valid <= 1'b1;
              mem_req_addr  <= {in_result[31:2], 2'b00};
              mem_req_wen   <= in_mem_wen;
              mem_req_wdata <= in_mem_wen ? st_wdata : 32'b0;
              mem_req_wmask <= in_mem_wen ? st_wmask : 4'b0000;
              state         <= REQ;
            end else begin
              out_valid <= 1'b1;
              state     <= OUT;
            end
          end
        end
        REQ: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            state         <= WAIT;
          end
        end
        WAIT: begin
          if (mem_rsp_valid) begin
            if (!mem_req_wen) out_result <= load_data;
            out_valid <= 1'b1;
            state     <= OUT;
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit sitting between EXU and WBU in the ysyxsoc pipeline. It accepts one instruction at a time from EXU, issues at most one memory access over a simple request/response bus, aligns and extends load data, and presents the completed instruction to WBU on its valid/ready input. It is the producer for WBU's `in_*` interface. CSR, ebreak, ecall and mret information is carried through unchanged as a sideband bus.

## Interface
- Parameters: none.
- `clk`  in  1  sole clock; everything is on `posedge clk`.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  EXU has an instruction.
- `in_ready`  out  1  equals `state==IDLE`.
- `in_pc`  in  32  instruction PC.
- `in_inst`  in  32  instruction word; `funct3 = in_inst[14:12]`.
- `in_result`  in  32  ALU result; this is the effective address for memory operations.
- `in_wdata`  in  32  store data (rs2).
- `in_rd`  in  5  destination register.
- `in_reg_wen`  in  1  register write enable.
- `in_mem_ren`  in  1  load.
- `in_mem_wen`  in  1  store.
- `in_side`  in  49  `{is_csr, csr_wen, csr_addr[11:0], csr_wdata[31:0], ebreak, ecall, mret}`.
- `mem_req_valid`  out  1  request valid.
- `mem_req_ready`  in  1  request accepted.
- `mem_req_addr`  out  32  `{addr[31:2],2'b00}`.
- `mem_req_wen`  out  1  1 = write.
- `mem_req_wdata`  out  32  lane-replicated store data.
- `mem_req_wmask`  out  4  byte strobes; `4'b0000` for reads.
- `mem_rsp_valid`  in  1  one-cycle response pulse.
- `mem_rsp_rdata`  in  32  aligned read word.
- `out_valid`  out  1  result for WBU.
- `out_ready`  in  1  WBU ready.
- `out_pc`, `out_inst`, `out_result`  out  32 each  to WBU.
- `out_rd`  out  5  to WBU.
- `out_reg_wen`  out  1  to WBU; forced to 0 when rd is 0.
- `out_side`  out  49  registered copy of `in_side`.

## Operation
- States: IDLE, REQ, WAIT, OUT. All payload is held in registers that are latched in IDLE.
- IDLE, `in_valid`=1: latch every input field.
  - Go to REQ if `mem_ren|mem_wen`, else go to OUT with `out_result=in_result`.
- REQ: `mem_req_valid`=1, with address, wen, wdata and wmask stable. Move to WAIT on the cycle `mem_req_ready`=1.
  - `mem_rsp_valid` seen while in REQ or IDLE is ignored.
- WAIT: on `mem_rsp_valid`, compute the result and go to OUT.
  - For stores, `out_result` keeps the latched address.
- OUT: `out_valid`=1. Go to IDLE on `out_ready`=1. Outputs are held stable while stalled.
- If both ren and wen are set, treat the instruction as a store.
- Store strobes and data (off = `addr[1:0]`):
  - funct3=0 (SB): wmask `4'b0001<<off`, wdata `{4{wd[7:0]}}`.
  - funct3=1 (SH): wmask `4'b0011<<{off[1],1'b0}`, wdata `{2{wd[15:0]}}`.
  - funct3=2 (SW): wmask `4'b1111`, wdata `wd`.
- Load extract:
  - LB(0) / LBU(4): byte `rdata[8*off+:8]`, sign- or zero-extended.
  - LH(1) / LHU(5): half `rdata[16*off[1]+:16]`, sign- or zero-extended.
  - LW(2): the whole word; `off` is ignored.
  - Other funct3 values behave as LW.
- Misaligned accesses are not trapped. They are issued word-aligned, with strobes and extraction as defined above.

## Timing
- Reset (asynchronous, immediate): state = IDLE, so `in_ready`=1. `mem_req_valid`=0, `out_valid`=0, and all registered outputs are 0, including `mem_req_wmask` and `out_side`.
- Non-memory instruction accepted in cycle N: `out_valid` in N+1.
- Memory instruction accepted in cycle N: `mem_req_valid` in N+1. With ready in cycle R, the response is first sampled in R+1. A response in cycle M gives `out_valid` in M+1.
- Minimum load/store latency is accept to `out_valid` = 3 cycles.
- Throughput is one instruction per at least 2 cycles. There is no back-to-back acceptance, because `in_ready`=0 during the OUT cycle.
- Reset during REQ or WAIT abandons the access. A late `mem_rsp_valid` after reset is ignored in IDLE.

## Test plan
- ALU op: pc=0x80000000, result=0x1234, rd=5, reg_wen=1 → `out_valid` 1 cycle after accept, `out_result`=0x1234, `out_reg_wen`=1.
- SB: addr=0x80000103, wdata=0xAABBCCDD → req addr 0x80000100, wmask 4'b1000, wdata 0xDDDDDDDD, wen=1. Then `out_valid` after rsp.
- LB vs LBU: addr offset 2, rdata=0x00F00000 → LB gives 0xFFFFFFF0, LBU gives 0x000000F0. LH at offset 2 with rdata=0x80010000 gives 0xFFFF8001.
- Backpressure: `mem_req_ready`=0 for 3 cycles → req fields stable throughout. `out_ready`=0 for 4 cycles → `out_*` stable, `in_ready`=0.
- Load with rd=0, reg_wen=1 → `out_reg_wen`=0. `in_side` pattern 0x1_5A5A_5A5A_5A5A passes through to `out_side` unchanged.
- Reset asserted in WAIT, then `mem_rsp_valid` pulsed → no `out_valid`, `in_ready`=1, all outputs 0.
